rx_symbol_phase_search: RTL and testbench

- Sits between the GoldStandardMatched receive filter output and the MER measurement block; it replaces manual sample-phase selection from switches.
- Accumulates the magnitude of the matched-filter output at each of SPS sample phases over a window of symbols, then locks to the phase with the largest accumulated magnitude (the widest eye opening).
- Once locked, emits one 1s17 decision sample per symbol, taken at the locked phase, to the MER block.

---
 rtl/rx_symbol_phase_search_if.sv | 23 ++
 rtl/rx_symbol_phase_search.sv | 76 +++++++
 tb/tb_rx_symbol_phase_search.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rx_symbol_phase_search_if.sv
// rx_symbol_phase_search_if: sample stream in, per-symbol decisions and lock status out
interface rx_symbol_phase_search_if #(parameter int SPS = 4);
  localparam int PW = $clog2(SPS);
  logic sam_clk_ena;
  logic sym_clk_ena;
  logic signed [17:0] rx_in;
  logic start;
  logic override_en;
  logic [PW-1:0] override_phase;
  logic signed [17:0] decision_out;
  logic decision_valid;
  logic [PW-1:0] best_phase;
  logic locked;
  logic searching;
  modport master (
    output sam_clk_ena, sym_clk_ena, rx_in, start, override_en, override_phase,
    input decision_out, decision_valid, best_phase, locked, searching
  );
  modport slave (
    input sam_clk_ena, sym_clk_ena, rx_in, start, override_en, override_phase,
    output decision_out, decision_valid, best_phase, locked, searching
  );
endinterface

// File: rtl/rx_symbol_phase_search.sv
// rx_symbol_phase_search: picks the sample phase with the largest summed magnitude and emits one decision per symbol
module rx_symbol_phase_search #(
  parameter int SPS = 4,
  parameter int LOG2_NSYM = 10
) (
  input logic sys_clk,
  input logic reset,
  rx_symbol_phase_search_if.slave bus
);
  localparam int PW = $clog2(SPS);
  localparam int AW = 18 + LOG2_NSYM;
  localparam logic [LOG2_NSYM:0] NSYM = (LOG2_NSYM+1)'(1 << LOG2_NSYM);
  localparam logic [PW-1:0] LAST = PW'(SPS - 1);
  typedef enum logic [1:0] {IDLE, SEARCH, COMPARE, TRACK} state_t;
  state_t state, state_nx;
  logic [PW-1:0] phase_cnt, phase_cur, cmp_idx, best_idx, win_idx, active;
  logic [AW-1:0] acc [SPS];
  logic [AW-1:0] best_val;
  logic [LOG2_NSYM:0] sym_cnt;
  logic [17:0] mag;
  logic take, win_done, upd, dec_hit;
  // Phase of the incoming sample: 0 on the symbol strobe, counting up after it.
  // The window starts at the first strobe seen in SEARCH and ends on the strobe
  // that would make NSYM complete symbols; that strobe sample is not summed.
  always_comb begin
    phase_cur = bus.sym_clk_ena ? '0 : phase_cnt + 1'b1;
    mag = !bus.rx_in[17] ? 18'(bus.rx_in) : bus.rx_in[16:0] == '0 ? 18'h1ffff : 18'(-bus.rx_in);
    win_done = state == SEARCH && bus.sam_clk_ena && bus.sym_clk_ena && sym_cnt == NSYM;
    take = state == SEARCH && bus.sam_clk_ena && (bus.sym_clk_ena ? sym_cnt != NSYM : sym_cnt != '0);
    upd = cmp_idx == '0 || acc[cmp_idx] > best_val;
    win_idx = upd ? cmp_idx : best_idx;
    active = bus.override_en ? bus.override_phase : bus.best_phase;
    dec_hit = bus.sam_clk_ena && (bus.override_en || state == TRACK) && phase_cur == active;
    state_nx = bus.start ? SEARCH :
               win_done ? COMPARE :
               state == COMPARE && cmp_idx == LAST ? TRACK : state;
  end
  // State register
  always_ff @(posedge sys_clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Phase counter, window accumulation, phase scan and decision capture
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      phase_cnt <= '0;
      sym_cnt <= '0;
      cmp_idx <= '0;
      best_idx <= '0;
      best_val <= '0;
      for (int i = 0; i < SPS; i++) acc[i] <= '0;
      bus.best_phase <= '0;
      bus.decision_out <= '0;
      bus.decision_valid <= 1'b0;
    end else begin
      if (bus.sam_clk_ena) phase_cnt <= phase_cur;
      if (bus.start) begin
        for (int i = 0; i < SPS; i++) acc[i] <= '0;
        sym_cnt <= '0;
        cmp_idx <= '0;
      end else begin
        if (take) acc[phase_cur] <= acc[phase_cur] + AW'(mag);
        if (take && bus.sym_clk_ena) sym_cnt <= sym_cnt + 1'b1;
        if (state == COMPARE) begin
          cmp_idx <= cmp_idx + 1'b1;
          best_val <= upd ? acc[cmp_idx] : best_val;
          best_idx <= win_idx;
          if (cmp_idx == LAST) bus.best_phase <= win_idx;
        end
      end
      bus.decision_valid <= dec_hit;
      if (dec_hit) bus.decision_out <= bus.rx_in;
    end
  end
  assign bus.locked = state == TRACK;
  assign bus.searching = state == SEARCH || state == COMPARE;
endmodule

// File: tb/tb_rx_symbol_phase_search.sv
// tb_rx_symbol_phase_search: directed checks of phase search, lock timing, decisions, override and reset
module tb_rx_symbol_phase_search;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int ph = 0;
  logic chk_dec = 1'b0;
  logic dec_on = 1'b0;
  int act = 0;
  logic signed [17:0] pat [4];
  rx_symbol_phase_search_if #(.SPS(4)) bus ();
  rx_symbol_phase_search #(.SPS(4), .LOG2_NSYM(4)) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic samples(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (chk_dec) check_eq("valid_low", 32'(bus.decision_valid), 0);
      bus.sam_clk_ena = 1'b1;
      bus.sym_clk_ena = ph == 0;
      bus.rx_in = pat[ph];
      @(negedge sys_clk);
      bus.sam_clk_ena = 1'b0;
      bus.sym_clk_ena = 1'b0;
      if (chk_dec) begin
        check_eq("valid", 32'(bus.decision_valid), 32'(dec_on && ph == act));
        if (dec_on && ph == act) check_eq("decision", 32'(bus.decision_out), 32'(pat[ph]));
      end
      ph = (ph + 1) % 4;
    end
  endtask
  task automatic pulse_start();
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask
  task automatic lock_check();
    check_eq("searching_cmp", 32'(bus.searching), 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge sys_clk);
      check_eq("locked_timing", 32'(bus.locked), 32'(i == 4));
    end
    check_eq("searching_done", 32'(bus.searching), 0);
  endtask
  task automatic check_zero(input string tag);
    check_eq({tag, "_dout"}, 32'(bus.decision_out), 0);
    check_eq({tag, "_valid"}, 32'(bus.decision_valid), 0);
    check_eq({tag, "_best"}, 32'(bus.best_phase), 0);
    check_eq({tag, "_locked"}, 32'(bus.locked), 0);
    check_eq({tag, "_searching"}, 32'(bus.searching), 0);
    check_eq({tag, "_state"}, 32'(dut.state), 0);
  endtask
  initial begin
    bus.sam_clk_ena = 1'b0;
    bus.sym_clk_ena = 1'b0;
    bus.rx_in = '0;
    bus.start = 1'b0;
    bus.override_en = 1'b0;
    bus.override_phase = '0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    check_zero("reset");
    pat = '{-18'sd1000, 18'sd1000, 18'sd65536, -18'sd1000};
    pulse_start();
    samples(65);
    lock_check();
    check_eq("main_best", 32'(bus.best_phase), 2);
    chk_dec = 1'b1;
    dec_on = 1'b1;
    act = 2;
    samples(12);
    chk_dec = 1'b0;
    pat = '{18'sd0, 18'sd40000, 18'sd0, -18'sd40000};
    pulse_start();
    samples(3);
    samples(65);
    lock_check();
    check_eq("tie_best", 32'(bus.best_phase), 1);
    pat = '{-18'sd131072, 18'sd0, 18'sd0, 18'sd0};
    pulse_start();
    samples(3);
    samples(65);
    lock_check();
    check_eq("sat_acc0", 32'(dut.acc[0]), 2097136);
    check_eq("sat_best", 32'(bus.best_phase), 0);
    samples(1);
    pat = '{18'sd0, 18'sd10000, 18'sd131071, 18'sd131071};
    pulse_start();
    samples(2);
    pat = '{18'sd0, 18'sd10000, 18'sd0, 18'sd9000};
    samples(65);
    lock_check();
    check_eq("align_best", 32'(bus.best_phase), 1);
    pat = '{18'sd0, 18'sd0, 18'sd0, 18'sd131071};
    pulse_start();
    samples(23);
    check_eq("restart_searching", 32'(bus.searching), 1);
    check_eq("restart_unlocked", 32'(bus.locked), 0);
    check_eq("restart_old_best", 32'(bus.best_phase), 1);
    pat = '{18'sd0, 18'sd0, 18'sd5000, 18'sd0};
    pulse_start();
    samples(65);
    lock_check();
    check_eq("restart_best", 32'(bus.best_phase), 2);
    chk_dec = 1'b1;
    act = 2;
    samples(8);
    chk_dec = 1'b0;
    @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    check_zero("track_reset");
    ph = 0;
    pat = '{18'sd11, -18'sd22, 18'sd33, -18'sd44};
    bus.override_en = 1'b1;
    bus.override_phase = 2'd3;
    chk_dec = 1'b1;
    dec_on = 1'b1;
    act = 3;
    samples(8);
    check_eq("override_unlocked", 32'(bus.locked), 0);
    bus.override_en = 1'b0;
    dec_on = 1'b0;
    samples(4);
    check_eq("override_hold", 32'(bus.decision_out), 32'(-18'sd44));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
